resp_checker_1b: RTL and testbench

RESP_CHECKER_1B -- requirements
Module: resp_checker_1b

---
 rtl/resp_chk_pkg.sv | 19 +
 rtl/resp_chk_delay.sv | 45 ++++
 rtl/resp_checker_1b.sv | 159 +++++++++++++++
 tb/tb_resp_checker_1b.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resp_chk_pkg.sv
// Shared types and constants for the 1-bit response checker.
// Holds the run-control FSM state encoding and the delay-line depth limit
// used to size the FILL-phase counter.
package resp_chk_pkg;

  // Deepest response delay the checker is built to align against.
  localparam int LATENCY_MAX = 4;

  // Wide enough to count LATENCY_MAX FILL cycles.
  localparam int FILL_W = $clog2(LATENCY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/resp_chk_delay.sv
// Stimulus delay line that aligns x with a DUT response arriving LATENCY cycles later.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over shift),
//        in (stimulus bit), out (in delayed LATENCY cycles; LATENCY=0 is a plain wire).
module resp_chk_delay #(
  parameter int LATENCY = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in,
  output logic out
);

  generate
    if (LATENCY == 0) begin : g_wire
      assign out = in;

      // Clock, reset and clear have no job when there is nothing to store.
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, clr};
    end else begin : g_shift
      logic [LATENCY-1:0] sr_q;
      logic [LATENCY-1:0] sr_d;

      // Shift every cycle; the checker only looks at the tap while aligned.
      always_comb begin
        sr_d = (sr_q << 1) | LATENCY'(in);
        if (clr) begin
          sr_d = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end

      assign out = sr_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/resp_checker_1b.sv
// Run-based checker for a 1-bit inverter DUT: compares out against ~x delayed LATENCY cycles.
// Ports: clk, rst_n (async active-low); start/stop run control; x stimulus, out DUT response;
//        busy/done/pass status, err_pulse per mismatch, err_cnt, sample_cnt, first_err_idx.
// Optional: define RESP_CHK_FIRST_ERR_EN to build the first-mismatch index capture register;
//           otherwise first_err_idx is tied to 0.
module resp_checker_1b
  import resp_chk_pkg::*;
#(
  parameter int LATENCY     = 0,
  parameter int CNT_W       = 8,
  parameter int NUM_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam state_e            RUN_ENTRY = (LATENCY > 0) ? FILL : RUN;

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;

  logic clr;
  logic x_dly;
  logic mismatch;
  logic run_last;

  // A start is only honoured from IDLE or DONE; it wipes the previous run.
  assign clr = start && ((state_q == IDLE) || (state_q == DONE));

  resp_chk_delay #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .in   (x),
    .out  (x_dly)
  );

  assign mismatch = (state_q == RUN) && (out != ~x_dly);

  // The current RUN sample is counted even when stop ends the run.
  assign run_last = stop || (sample_cnt_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN_ENTRY;
      FILL: begin
        if (stop) begin
          state_d = DONE;
        end else if (fill_cnt_q == FILL_LAST) begin
          state_d = RUN;
        end
      end
      RUN:  if (run_last) state_d = DONE;
      DONE: if (start) state_d = RUN_ENTRY;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == FILL) || (state_q == RUN);
    done      = (state_q == DONE);
    pass      = done && (err_cnt_q == '0);
    err_pulse = mismatch;
  end

  // Counters
  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    err_cnt_d    = err_cnt_q;
    sample_cnt_d = sample_cnt_q;
    if (clr) begin
      fill_cnt_d   = '0;
      err_cnt_d    = '0;
      sample_cnt_d = '0;
    end else begin
      if (state_q == FILL) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
      if (state_q == RUN) begin
        sample_cnt_d = sample_cnt_q + 1'b1;
        if (mismatch && (err_cnt_q != CNT_MAX)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q   <= '0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign err_cnt    = err_cnt_q;
  assign sample_cnt = sample_cnt_q;

`ifdef RESP_CHK_FIRST_ERR_EN
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;

  // err_cnt never returns to zero within a run, so zero means "no mismatch yet".
  always_comb begin
    first_err_idx_d = first_err_idx_q;
    if (clr) begin
      first_err_idx_d = '0;
    end else if (mismatch && (err_cnt_q == '0)) begin
      first_err_idx_d = sample_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_idx_q <= '0;
    end else begin
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign first_err_idx = first_err_idx_q;
`else
  assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_resp_checker_1b.sv
// Self-checking bench for resp_checker_1b: vector table, directed run sequences,
// and randomized runs checked against a history-based reference model.
module tb_resp_checker_1b;

`ifdef RESP_CHK_FIRST_ERR_EN
  localparam bit FEI_EN = 1'b1;
`else
  localparam bit FEI_EN = 1'b0;
`endif
  localparam int LAT_B = 2;
  localparam int NS    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk  = 0;
  int n_pass = 0;

  // ---- DUT A: LATENCY=0, defaults ----
  logic       a_start, a_stop, a_x, a_drv, a_out, a_p1, a_p2;
  logic [1:0] a_mode;
  logic       a_busy, a_done, a_pass, a_pulse;
  logic [7:0] a_err, a_samp, a_fei;
  always @(posedge clk) begin
    a_p1 <= ~a_x;
    a_p2 <= a_p1;
  end
  // 0: correct inverter, 1: bench-driven, 2: inverter registered twice
  assign a_out = (a_mode == 2'd0) ? ~a_x : (a_mode == 2'd1) ? a_drv : a_p2;

  resp_checker_1b u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .x(a_x), .out(a_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_pulse(a_pulse),
    .err_cnt(a_err), .sample_cnt(a_samp), .first_err_idx(a_fei)
  );

  // ---- DUT B: LATENCY=2 ----
  logic       b_start, b_stop, b_x, b_drv, b_out, b_p1, b_p2, b_mode;
  logic       b_busy, b_done, b_pass, b_pulse;
  logic [7:0] b_err, b_samp, b_fei;
  always @(posedge clk) begin
    b_p1 <= ~b_x;
    b_p2 <= b_p1;
  end
  assign b_out = b_mode ? b_drv : b_p2;

  resp_checker_1b #(.LATENCY(LAT_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .x(b_x), .out(b_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_pulse(b_pulse),
    .err_cnt(b_err), .sample_cnt(b_samp), .first_err_idx(b_fei)
  );

  // ---- DUT C: CNT_W=3, NUM_SAMPLES=7, response stuck at x ----
  logic       c_start, c_stop, c_x;
  logic       c_busy, c_done, c_pass, c_pulse;
  logic [2:0] c_err, c_samp, c_fei;

  resp_checker_1b #(.CNT_W(3), .NUM_SAMPLES(7)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .stop(c_stop), .x(c_x), .out(c_x),
    .busy(c_busy), .done(c_done), .pass(c_pass), .err_pulse(c_pulse),
    .err_cnt(c_err), .sample_cnt(c_samp), .first_err_idx(c_fei)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fei(input int v);
    return FEI_EN ? v : 0;
  endfunction

  typedef struct {
    int start, stop, x, out;          // inputs for the cycle
    int pulse;                        // err_pulse during the cycle
    int busy, done, pass, err, samp;  // state after the edge
    int fe;                           // first mismatch index after the edge
  } vec_t;
  vec_t tbl[10];

  logic xh[$];
  int   samples, errs, first;
  bit   ended, exp_pulse;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_stop = 0; a_x = 0; a_drv = 0; a_mode = 2'd1;
    b_start = 0; b_stop = 0; b_x = 0; b_drv = 0; b_mode = 1'b0;
    c_start = 0; c_stop = 0; c_x = 0;

    // start stop x out | pulse | busy done pass err samp | fe
    tbl[0] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 2, 1};
    tbl[3] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 3, 1};
    tbl[4] = '{0, 0, 0, 0, 1, 1, 0, 0, 2, 4, 1};
    tbl[5] = '{0, 1, 1, 0, 0, 0, 1, 0, 2, 5, 1};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 1, 0, 2, 5, 1};
    tbl[7] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0};

    // Reset state
    #3;
    chk("rst busy", a_busy, 0);
    chk("rst done", a_done, 0);
    chk("rst pass", a_pass, 0);
    chk("rst pulse", a_pulse, 0);
    chk("rst err", a_err, 0);
    chk("rst samp", a_samp, 0);
    chk("rst fei", a_fei, 0);
    #9 rst_n = 1'b1;
    tick();

    // Vector table on DUT A
    for (int i = 0; i < 10; i++) begin
      a_start = (tbl[i].start != 0);
      a_stop  = (tbl[i].stop != 0);
      a_x     = (tbl[i].x != 0);
      a_drv   = (tbl[i].out != 0);
      #1;
      chk($sformatf("tbl%0d pulse", i), a_pulse, tbl[i].pulse);
      tick();
      chk($sformatf("tbl%0d busy", i), a_busy, tbl[i].busy);
      chk($sformatf("tbl%0d done", i), a_done, tbl[i].done);
      chk($sformatf("tbl%0d pass", i), a_pass, tbl[i].pass);
      chk($sformatf("tbl%0d err", i), a_err, tbl[i].err);
      chk($sformatf("tbl%0d samp", i), a_samp, tbl[i].samp);
      chk($sformatf("tbl%0d fei", i), a_fei, fei(tbl[i].fe));
    end
    a_start = 0; a_stop = 0;

    // Correct inverter, random x, 16 samples
    a_mode = 2'd0; a_start = 1; tick(); a_start = 0;
    for (int i = 0; i < NS; i++) begin
      a_x = 1'($urandom);
      #1 chk("good pulse", a_pulse, 0);
      tick();
    end
    chk("good done", a_done, 1);
    chk("good pass", a_pass, 1);
    chk("good err", a_err, 0);
    chk("good samp", a_samp, 16);
    chk("good busy", a_busy, 0);

    // Response stuck at 0, x alternating 1,0
    a_mode = 2'd1; a_drv = 0; a_start = 1; tick(); a_start = 0;
    for (int i = 0; i < NS; i++) begin
      a_x = ((i % 2) == 0);
      tick();
    end
    chk("stuck0 err", a_err, 8);
    chk("stuck0 fei", a_fei, fei(1));
    chk("stuck0 pass", a_pass, 0);
    chk("stuck0 done", a_done, 1);

    // Two-register DUT checked with LATENCY=0: every sample misaligned
    a_mode = 2'd2;
    for (int j = 0; j < 20; j++) begin
      a_x = j[1];
      a_start = (j == 3);
      tick();
    end
    chk("lat0 misalign err", a_err, 16);
    chk("lat0 misalign pass", a_pass, 0);
    chk("lat0 misalign done", a_done, 1);

    // Two-register DUT on LATENCY=2 checker: two FILL cycles, then clean run
    b_mode = 1'b0;
    for (int j = 0; j < 19; j++) begin
      b_x = 1'($urandom);
      b_start = (j == 0);
      #1 chk("lat2 pulse", b_pulse, 0);
      tick();
      if (j == 2) begin
        chk("lat2 fill busy", b_busy, 1);
        chk("lat2 fill samp", b_samp, 0);
      end
      if (j == 3) chk("lat2 first samp", b_samp, 1);
    end
    chk("lat2 done", b_done, 1);
    chk("lat2 pass", b_pass, 1);
    chk("lat2 err", b_err, 0);
    chk("lat2 samp", b_samp, 16);

    // Stop during FILL
    b_start = 1; tick(); b_start = 0; b_stop = 1; tick(); b_stop = 0;
    chk("fillstop done", b_done, 1);
    chk("fillstop pass", b_pass, 1);
    chk("fillstop samp", b_samp, 0);
    chk("fillstop busy", b_busy, 0);

    // Narrow counters, response stuck at x
    c_start = 1; tick(); c_start = 0;
    for (int i = 0; i < 7; i++) begin
      c_x = 1'($urandom);
      #1 chk("narrow pulse", c_pulse, 1);
      tick();
    end
    chk("narrow err", c_err, 7);
    chk("narrow samp", c_samp, 7);
    chk("narrow done", c_done, 1);
    chk("narrow pass", c_pass, 0);
    chk("narrow fei", c_fei, fei(0));

    // Randomized runs on LATENCY=2 against a history model
    b_mode = 1'b1;
    for (int r = 0; r < 10; r++) begin
      xh.delete();
      samples = 0; errs = 0; first = 0; ended = 0;
      b_start = 1; b_stop = 0; tick(); b_start = 0;
      for (int k = 0; k < LAT_B + NS + 2 && !ended; k++) begin
        b_x = 1'($urandom);
        b_drv = 1'($urandom);
        b_stop = ($urandom_range(0, 19) == 0);
        xh.push_back(b_x);
        exp_pulse = 1'b0;
        if (k >= LAT_B) begin
          exp_pulse = (b_drv != !xh[k - LAT_B]);
          if (exp_pulse) begin
            if (errs == 0) first = samples;
            errs++;
          end
          samples++;
          ended = b_stop || (samples == NS);
        end else begin
          ended = b_stop;
        end
        #1 chk($sformatf("rnd%0d pulse k%0d", r, k), b_pulse, exp_pulse);
        tick();
        chk($sformatf("rnd%0d busy k%0d", r, k), b_busy, !ended);
      end
      b_stop = 0;
      chk($sformatf("rnd%0d ended", r), ended, 1);
      chk($sformatf("rnd%0d done", r), b_done, 1);
      chk($sformatf("rnd%0d samp", r), b_samp, samples);
      chk($sformatf("rnd%0d err", r), b_err, errs);
      chk($sformatf("rnd%0d pass", r), b_pass, errs == 0);
      chk($sformatf("rnd%0d fei", r), b_fei, fei(first));
    end

    // Stop at sample 5, then restart
    a_mode = 2'd0; a_start = 1; tick(); a_start = 0;
    for (int i = 0; i < 6; i++) begin
      a_x = 1'($urandom);
      a_stop = (i == 5);
      tick();
    end
    a_stop = 0;
    chk("stop5 samp", a_samp, 6);
    chk("stop5 done", a_done, 1);
    chk("stop5 busy", a_busy, 0);
    a_start = 1; tick(); a_start = 0;
    chk("restart samp", a_samp, 0);
    chk("restart err", a_err, 0);
    chk("restart busy", a_busy, 1);
    chk("restart done", a_done, 0);

    // Seven mismatching samples with a start while busy, then async reset
    a_mode = 2'd1; a_drv = 1; a_x = 1;
    for (int i = 0; i < 7; i++) begin
      a_start = (i == 2);
      #1 chk("midrun pulse", a_pulse, 1);
      tick();
    end
    a_start = 0;
    chk("midrun samp", a_samp, 7);
    chk("midrun err", a_err, 7);
    chk("midrun busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", a_busy, 0);
    chk("arst done", a_done, 0);
    chk("arst pass", a_pass, 0);
    chk("arst pulse", a_pulse, 0);
    chk("arst err", a_err, 0);
    chk("arst samp", a_samp, 0);
    chk("arst fei", a_fei, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post-rst busy", a_busy, 0);
    chk("post-rst done", a_done, 0);
    a_start = 1; a_stop = 1; tick(); a_start = 0; a_stop = 0;
    chk("start+stop busy", a_busy, 1);
    chk("start+stop done", a_done, 0);
    tick();
    chk("start+stop samp", a_samp, 1);
    chk("start+stop still busy", a_busy, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
